// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake between a host and the memory access controller.
// The host drives requests through the master modport; the controller serves them via slave.
interface mem_access_ctrl_if #(
   parameter int WORD_W = 8,
   parameter int OP_W   = 3
);
   localparam int AW = WORD_W - OP_W;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [AW-1:0]     req_addr;
   logic [WORD_W-1:0] req_wdata;
   logic              resp_valid;
   logic [WORD_W-1:0] resp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences one host request into MAR/MDR/CS bus cycles on a shared tri-state sysbus.
// Strobes and response are registered; sysbus is driven only while presenting address or data.
module mem_access_ctrl #(
   parameter int WORD_W = 8,
   parameter int OP_W   = 3
) (
   input  logic              clock,
   input  logic              n_reset,
   mem_access_ctrl_if.slave  host,
   output logic              load_MAR,
   output logic              load_MDR,
   output logic              MDR_bus,
   output logic              CS,
   output logic              R_NW,
   inout  wire  [WORD_W-1:0] sysbus
);
   localparam int AW = WORD_W - OP_W;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StWdata,
      StWstrobe,
      StRstrobe,
      StRcapt
   } state_e;

   state_e            state;
   logic              write_q;
   logic [AW-1:0]     addr_q;
   logic [WORD_W-1:0] wdata_q;
   logic [WORD_W-1:0] bus_out;
   logic              bus_oe;

   // Bus drive is decoded from the registered state, so it is glitch-free at state boundaries.
   always_comb begin
      bus_oe  = 1'b0;
      bus_out = '0;
      unique case (state)
         StAddr: begin
            bus_oe  = 1'b1;
            bus_out = {{OP_W{1'b0}}, addr_q};
         end
         StWdata: begin
            bus_oe  = 1'b1;
            bus_out = wdata_q;
         end
         default: begin
            bus_oe  = 1'b0;
            bus_out = '0;
         end
      endcase
   end

   assign sysbus = bus_oe ? bus_out : {WORD_W{1'bz}};

   // Outputs are set on the edge that enters the state they belong to.
   always_ff @(posedge clock) begin
      if (!n_reset) begin
         state           <= StIdle;
         write_q         <= 1'b0;
         addr_q          <= '0;
         wdata_q         <= '0;
         load_MAR        <= 1'b0;
         load_MDR        <= 1'b0;
         MDR_bus         <= 1'b0;
         CS              <= 1'b0;
         R_NW            <= 1'b1;
         host.req_ready  <= 1'b1;
         host.resp_valid <= 1'b0;
         host.resp_rdata <= '0;
      end else begin
         load_MAR        <= 1'b0;
         load_MDR        <= 1'b0;
         MDR_bus         <= 1'b0;
         CS              <= 1'b0;
         R_NW            <= 1'b1;
         host.req_ready  <= 1'b0;
         host.resp_valid <= 1'b0;
         unique case (state)
            StIdle: begin
               if (host.req_valid) begin
                  write_q  <= host.req_write;
                  addr_q   <= host.req_addr;
                  wdata_q  <= host.req_wdata;
                  load_MAR <= 1'b1;
                  state    <= StAddr;
               end else begin
                  host.req_ready <= 1'b1;
               end
            end
            StAddr: begin
               if (write_q) begin
                  load_MDR <= 1'b1;
                  state    <= StWdata;
               end else begin
                  CS    <= 1'b1;
                  state <= StRstrobe;
               end
            end
            StWdata: begin
               CS    <= 1'b1;
               R_NW  <= 1'b0;
               state <= StWstrobe;
            end
            StWstrobe: begin
               host.resp_valid <= 1'b1;
               host.req_ready  <= 1'b1;
               state           <= StIdle;
            end
            StRstrobe: begin
               MDR_bus <= 1'b1;
               state   <= StRcapt;
            end
            StRcapt: begin
               host.resp_rdata <= sysbus;
               host.resp_valid <= 1'b1;
               host.req_ready  <= 1'b1;
               state           <= StIdle;
            end
            default: begin
               host.req_ready <= 1'b1;
               state          <= StIdle;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized checks of mem_access_ctrl against a RAM/device responder and
// an address-map reference model.
module tb_mem_access_ctrl;
   localparam int WORD_W = 8;
   localparam int OP_W   = 3;
   localparam int AW     = WORD_W - OP_W;

   logic clock = 1'b0;
   logic n_reset = 1'b0;
   logic load_MAR, load_MDR, MDR_bus, CS, R_NW;
   tri1 [WORD_W-1:0] sysbus;

   int checks = 0;
   int errors = 0;

   mem_access_ctrl_if #(.WORD_W(WORD_W), .OP_W(OP_W)) host ();

   mem_access_ctrl #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
      .clock    (clock),
      .n_reset  (n_reset),
      .host     (host),
      .load_MAR (load_MAR),
      .load_MDR (load_MDR),
      .MDR_bus  (MDR_bus),
      .CS       (CS),
      .R_NW     (R_NW),
      .sysbus   (sysbus)
   );

   always #5 clock = ~clock;

   // Responders: RAM in the upper half of the address space, a read-only device below.
   logic [AW-1:0]     mar = '0;
   logic [WORD_W-1:0] mdr = '0;
   logic [WORD_W-1:0] ram [32] = '{default: 8'h00};

   function automatic logic [7:0] dev_val(input logic [AW-1:0] a);
      return 8'hC6 ^ {3'b000, a};
   endfunction

   assign sysbus = MDR_bus ? mdr : {WORD_W{1'bz}};

   always @(posedge clock) begin
      if (load_MAR) mar <= sysbus[AW-1:0];
      if (load_MDR) mdr <= sysbus;
      if (CS && !R_NW && mar[AW-1]) ram[mar] <= mdr;
      if (CS && R_NW) mdr <= mar[AW-1] ? ram[mar] : dev_val(mar);
   end

   // Reference model: what a read of each address should return.
   logic [7:0] ref_mem [int];
   logic [7:0] last_rd = 8'h00;

   function automatic logic [7:0] ref_read(input int a);
      if (a >= 16) return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
      return 8'hC6 ^ 8'(a);
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock, then the invariants that hold in every cycle.
   task automatic step();
      @(posedge clock);
      #1;
      chk1("strobe_onehot", ($countones({load_MAR, load_MDR, CS, MDR_bus}) <= 1), 1'b1);
      if (!CS) chk1("rnw_without_cs", R_NW, 1'b1);
      if (!(load_MAR || load_MDR || MDR_bus)) chk8("bus_undriven", sysbus, 8'hFF);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         chk1("idle_resp", host.resp_valid, 1'b0);
         chk1("idle_ready", host.req_ready, 1'b1);
      end
   endtask

   // Offer a request now (controller must be idle) and follow it through its response cycle.
   task automatic do_txn(input logic wr, input logic [AW-1:0] a, input logic [7:0] d,
                         input bit hold);
      logic [7:0] exp_rd;
      host.req_valid = 1'b1;
      host.req_write = wr;
      host.req_addr  = a;
      host.req_wdata = d;
      chk1("ready_at_accept", host.req_ready, 1'b1);
      step();
      if (hold) begin
         host.req_write = 1'($urandom);
         host.req_addr  = AW'($urandom);
         host.req_wdata = 8'($urandom);
      end else begin
         host.req_valid = 1'b0;
      end
      chk1("c1_load_mar", load_MAR, 1'b1);
      chk8("c1_bus_addr", sysbus, {3'b000, a});
      chk1("c1_ready", host.req_ready, 1'b0);
      chk1("c1_resp", host.resp_valid, 1'b0);
      step();
      if (wr) begin
         chk1("c2_load_mdr", load_MDR, 1'b1);
         chk8("c2_bus_wdata", sysbus, d);
      end else begin
         chk1("c2_cs_read", CS, 1'b1);
         chk1("c2_rnw_read", R_NW, 1'b1);
      end
      chk1("c2_resp", host.resp_valid, 1'b0);
      step();
      if (wr) begin
         chk1("c3_cs_write", CS, 1'b1);
         chk1("c3_rnw_write", R_NW, 1'b0);
      end else begin
         chk1("c3_mdr_bus", MDR_bus, 1'b1);
      end
      chk1("c3_resp", host.resp_valid, 1'b0);
      step();
      chk1("c4_resp_valid", host.resp_valid, 1'b1);
      chk1("c4_ready", host.req_ready, 1'b1);
      if (wr) begin
         if (a >= 16) ref_mem[int'(a)] = d;
         chk8("c4_rdata_kept", host.resp_rdata, last_rd);
      end else begin
         exp_rd = ref_read(int'(a));
         chk8("c4_rdata", host.resp_rdata, exp_rd);
         last_rd = exp_rd;
      end
      host.req_valid = 1'b0;
   endtask

   initial begin
      host.req_valid = 1'b0;
      host.req_write = 1'b0;
      host.req_addr  = '0;
      host.req_wdata = '0;

      step();
      step();
      chk1("rst_resp_valid", host.resp_valid, 1'b0);
      chk8("rst_rdata", host.resp_rdata, 8'h00);
      chk1("rst_load_mar", load_MAR, 1'b0);
      chk1("rst_load_mdr", load_MDR, 1'b0);
      chk1("rst_mdr_bus", MDR_bus, 1'b0);
      chk1("rst_cs", CS, 1'b0);
      chk1("rst_rnw", R_NW, 1'b1);
      n_reset = 1'b1;
      step();
      chk1("ready_after_release", host.req_ready, 1'b1);
      idle(1);

      // Directed: write, read back from RAM, read from device.
      do_txn(1'b1, 5'h13, 8'h5A, 1'b0);
      idle(2);
      do_txn(1'b0, 5'h13, 8'h00, 1'b0);
      idle(1);
      do_txn(1'b0, 5'h05, 8'h00, 1'b0);
      idle(1);

      // Back-to-back with req_valid held high throughout.
      do_txn(1'b1, 5'h1F, 8'h81, 1'b1);
      do_txn(1'b0, 5'h1F, 8'h00, 1'b1);
      do_txn(1'b0, 5'h10, 8'h00, 1'b1);
      chk8("b2b_last_rdata", last_rd, 8'h00);
      idle(1);
      do_txn(1'b0, 5'h1F, 8'h00, 1'b0);
      chk8("b2b_1f_rdata", host.resp_rdata, 8'h81);
      idle(1);

      // Reset during RSTROBE abandons the read.
      host.req_valid = 1'b1;
      host.req_write = 1'b0;
      host.req_addr  = 5'h1F;
      step();
      host.req_valid = 1'b0;
      step();
      chk1("pre_rst_cs", CS, 1'b1);
      n_reset = 1'b0;
      step();
      chk1("mid_rst_cs", CS, 1'b0);
      chk1("mid_rst_resp", host.resp_valid, 1'b0);
      chk8("mid_rst_rdata", host.resp_rdata, 8'h00);
      chk1("mid_rst_mdr_bus", MDR_bus, 1'b0);
      n_reset = 1'b1;
      last_rd = 8'h00;
      step();
      chk1("post_rst_ready", host.req_ready, 1'b1);
      chk1("post_rst_resp", host.resp_valid, 1'b0);
      idle(3);

      // Randomized traffic with random gaps, holds and back-to-back requests.
      for (int n = 0; n < 60; n++) begin
         logic          wr;
         logic [AW-1:0] a;
         int            gap;
         wr  = 1'($urandom_range(0, 1));
         a   = AW'($urandom_range(0, 31));
         gap = $urandom_range(0, 2);
         do_txn(wr, a, 8'($urandom), 1'($urandom_range(0, 1)));
         if (gap > 0) idle(gap);
      end
      idle(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
